// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, widths and FSM state type for the RAM slave
package axi_pkg;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_MEM  = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        WR_RESP = 3'd4
    } state_e;

    // The RAM is one word wide, so anything wider than a word steps as a word.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd2) ? 3'd2 : size;
    endfunction
endpackage

// File: rtl/axi_slave_ram_if.sv
// rtl/axi_slave_ram_if.sv - AXI3 bus bundle between one master and the RAM slave
interface axi_slave_ram_if;
    import axi_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [31:0]       araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [31:0]       awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic [1:0]        awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_ram_mem.sv
// rtl/axi_ram_mem.sv - single-port synchronous word RAM, byte write enables, 1-cycle read
module axi_ram_mem #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (en) begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI3 RAM slave top; AXI_RAM_RESP_ERR_EN enables DECERR for out-of-range starts
module axi_slave_ram
    import axi_pkg::*;
#(
    parameter int          ADDR_W = 14,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    axi_slave_ram_if.slave  bus
);
    state_e            state, state_nxt;
    logic              last_rd;
    logic [ID_W-1:0]   id_q;
    logic [31:0]       addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [3:0]        cnt_q;
    logic              err_q;

    logic              ar_win, aw_win, req_err;
    logic              arready, awready, wready, rvalid, bvalid;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [31:0]       mem_q, addr_off, addr_next;
    logic              is_last;
    logic [1:0]        resp;

    // A read wins unless a write is also pending and the previous grant went to a read.
    assign ar_win = bus.arvalid && (!bus.awvalid || !last_rd);
    assign aw_win = bus.awvalid && !ar_win;

`ifdef AXI_RAM_RESP_ERR_EN
    logic [31:0] req_off;
    assign req_off = (ar_win ? bus.araddr : bus.awaddr) - BASE;
    assign req_err = {1'b0, req_off} >= (33'd1 << (ADDR_W + 2));
`else
    assign req_err = 1'b0;
`endif

    assign addr_off  = addr_q - BASE;
    assign addr_next = addr_q + ((burst_q == BURST_FIXED) ? 32'd0 : (32'd1 << size_q));
    assign is_last   = (cnt_q == len_q);
    assign resp      = err_q ? RESP_DECERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arready   = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        rvalid    = 1'b0;
        bvalid    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        case (state)
            IDLE: begin
                arready = ar_win && !rst;
                awready = aw_win && !rst;
                if (ar_win)      state_nxt = RD_MEM;
                else if (aw_win) state_nxt = WR_DATA;
            end
            RD_MEM: begin
                mem_en    = !err_q;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                rvalid = 1'b1;
                if (bus.rready) state_nxt = is_last ? IDLE : RD_MEM;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (bus.wvalid) begin
                    mem_we = err_q ? 4'b0000 : bus.wstrb;
                    if (is_last) state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bus.bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_rd <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_q <= '0;
                    err_q <= req_err;
                    if (ar_win) begin
                        last_rd <= 1'b1;
                        id_q    <= bus.arid;
                        addr_q  <= bus.araddr;
                        len_q   <= bus.arlen;
                        size_q  <= clamp_size(bus.arsize);
                        burst_q <= bus.arburst;
                    end else if (aw_win) begin
                        last_rd <= 1'b0;
                        id_q    <= bus.awid;
                        addr_q  <= bus.awaddr;
                        len_q   <= bus.awlen;
                        size_q  <= clamp_size(bus.awsize);
                        burst_q <= bus.awburst;
                    end
                end
                RD_DATA: if (bus.rready && !is_last) begin
                    addr_q <= addr_next;
                    cnt_q  <= cnt_q + 4'd1;
                end
                WR_DATA: if (bus.wvalid) begin
                    addr_q <= addr_next;
                    cnt_q  <= cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    axi_ram_mem #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_off[ADDR_W+1:2]),
        .wdata (bus.wdata),
        .rdata (mem_q)
    );

    assign bus.arready = arready;
    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.rvalid  = rvalid;
    assign bus.bvalid  = bvalid;
    assign bus.rdata   = (rvalid && !err_q) ? mem_q : 32'd0;
    assign bus.rid     = rvalid ? id_q : '0;
    assign bus.rresp   = rvalid ? resp : RESP_OKAY;
    assign bus.rlast   = rvalid && is_last;
    assign bus.bid     = bvalid ? id_q : '0;
    assign bus.bresp   = bvalid ? resp : RESP_OKAY;

    logic unused_ok;
    assign unused_ok = ^{bus.arlock, bus.arcache, bus.arprot, bus.awlock, bus.awcache,
                         bus.awprot, bus.wid, bus.wlast, addr_off};
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb/tb_axi_slave_ram.sv - directed self-checking bench for axi_slave_ram
module tb_axi_slave_ram;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_slave_ram_if bus();
    axi_slave_ram #(.ADDR_W(14), .BASE(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit to_flag  = 1'b0;

    function automatic bit sig(input int which);
        case (which)
            0:       return bus.arready;
            1:       return bus.awready;
            2:       return bus.wready;
            3:       return bus.rvalid;
            4:       return bus.bvalid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which);
        int n = 0;
        while (!sig(which) && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (!sig(which)) to_flag = 1'b1;
    endtask

    task automatic ar_issue(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        bus.araddr = addr; bus.arlen = len; bus.arburst = burst;
        bus.arsize = 3'd2; bus.arid = id; bus.arvalid = 1'b1;
        #1 wait_for(0);
        @(posedge clk); @(negedge clk);
        bus.arvalid = 1'b0;
    endtask

    task automatic aw_issue(input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [3:0] id);
        bus.awaddr = addr; bus.awlen = len; bus.awburst = burst;
        bus.awsize = 3'd2; bus.awid = id; bus.awvalid = 1'b1;
        #1 wait_for(1);
        @(posedge clk); @(negedge clk);
        bus.awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        #1 wait_for(2);
        @(posedge clk); @(negedge clk);
        bus.wvalid = 1'b0;
    endtask

    task automatic r_take(output logic [31:0] d, output logic [3:0] id,
                          output logic [1:0] resp, output logic last);
        #1 wait_for(3);
        d = bus.rdata; id = bus.rid; resp = bus.rresp; last = bus.rlast;
        bus.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic b_take(output logic [3:0] id, output logic [1:0] resp);
        #1 wait_for(4);
        id = bus.bid; resp = bus.bresp;
        bus.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic write_words(input logic [31:0] addr, input logic [3:0] len,
                               input logic [31:0] d0, d1, d2, d3);
        logic [3:0] id;
        logic [1:0] resp;
        aw_issue(addr, len, BURST_INCR, 4'd0);
        for (int i = 0; i <= int'(len); i++)
            w_beat(i == 0 ? d0 : i == 1 ? d1 : i == 2 ? d2 : d3, 4'hF);
        b_take(id, resp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid, bus.rlast});
        end
        checks++;
        if ({bus.rdata, bus.rid, bus.bid, bus.rresp, bus.bresp} !== 44'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus.rdata, bus.rid, bus.bid, bus.rresp, bus.bresp});
        end
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE);
        end
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        bus.araddr = 32'h200; bus.arlen = 4'd0; bus.arburst = BURST_INCR; bus.arsize = 3'd2; bus.arid = 4'd1;
        bus.awaddr = 32'h204; bus.awlen = 4'd0; bus.awburst = BURST_INCR; bus.awsize = 3'd2; bus.awid = 4'd2;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        #1;
        checks++;
        if ({bus.arready, bus.awready} !== 2'b10) begin
            failures++;
            $display("FAIL arb_tie1 got=%b exp=10", {bus.arready, bus.awready});
        end
        @(posedge clk); @(negedge clk);
        bus.arvalid = 1'b0;
        #1;
        checks++;
        if ({bus.arready, bus.awready} !== 2'b00) begin
            failures++;
            $display("FAIL arb_busy got=%b exp=00", {bus.arready, bus.awready});
        end
        r_take(d, id, resp, last);
        checks++;
        if (id !== 4'd1) begin
            failures++;
            $display("FAIL arb_rid got=%0d exp=1", id);
        end
        bus.araddr = 32'h204; bus.arid = 4'd4; bus.arvalid = 1'b1;
        #1;
        checks++;
        if ({bus.arready, bus.awready} !== 2'b01) begin
            failures++;
            $display("FAIL arb_tie2 got=%b exp=01", {bus.arready, bus.awready});
        end
        @(posedge clk); @(negedge clk);
        bus.awvalid = 1'b0;
        w_beat(32'hA5A5_0001, 4'hF);
        b_take(id, resp);
        checks++;
        if ({id, resp} !== {4'd2, 2'd0}) begin
            failures++;
            $display("FAIL arb_bid got=%h exp=%h", {id, resp}, {4'd2, 2'd0});
        end
        bus.awaddr = 32'h208; bus.awid = 4'd6; bus.awvalid = 1'b1;
        #1;
        checks++;
        if ({bus.arready, bus.awready} !== 2'b10) begin
            failures++;
            $display("FAIL arb_tie3 got=%b exp=10", {bus.arready, bus.awready});
        end
        @(posedge clk); @(negedge clk);
        bus.arvalid = 1'b0;
        r_take(d, id, resp, last);
        checks++;
        if ({d, id} !== {32'hA5A5_0001, 4'd4}) begin
            failures++;
            $display("FAIL arb_rdata got=%h exp=%h", {d, id}, {32'hA5A5_0001, 4'd4});
        end
        #1 wait_for(1);
        @(posedge clk); @(negedge clk);
        bus.awvalid = 1'b0;
        w_beat(32'h0, 4'hF);
        b_take(id, resp);
    endtask

    task automatic test_strobe_write;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        write_words(32'h80, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        aw_issue(32'h80, 4'd0, BURST_INCR, 4'd5);
        #1;
        checks++;
        if (bus.wready !== 1'b1) begin
            failures++;
            $display("FAIL wready_t1 got=%b exp=1", bus.wready);
        end
        w_beat(32'h1122_3344, 4'b0011);
        #1;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL bvalid_next got=%b exp=1", bus.bvalid);
        end
        b_take(id, resp);
        checks++;
        if ({id, resp} !== {4'd5, 2'd0}) begin
            failures++;
            $display("FAIL strobe_b got=%h exp=%h", {id, resp}, {4'd5, 2'd0});
        end
        ar_issue(32'h80, 4'd0, BURST_INCR, 4'd0);
        r_take(d, id, resp, last);
        checks++;
        if (d !== 32'h0000_3344) begin
            failures++;
            $display("FAIL strobe_data got=%h exp=00003344", d);
        end
    endtask

    task automatic test_single_read;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        write_words(32'h40, 4'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        ar_issue(32'h40, 4'd0, BURST_INCR, 4'd3);
        #1;
        checks++;
        if (bus.rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rvalid_t1 got=%b exp=0", bus.rvalid);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL rvalid_t2 got=%b exp=1", bus.rvalid);
        end
        r_take(d, id, resp, last);
        checks++;
        if ({d, id, resp, last} !== {32'hDEAD_BEEF, 4'd3, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_read got=%h exp=%h", {d, id, resp, last}, {32'hDEAD_BEEF, 4'd3, 2'd0, 1'b1});
        end
    endtask

    task automatic test_incr_burst;
        logic [31:0] d, held;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic [31:0] exp_d;
        write_words(32'h100, 4'd3, 32'hC0DE_0040, 32'hC0DE_0041, 32'hC0DE_0042, 32'hC0DE_0043);
        ar_issue(32'h100, 4'd3, BURST_INCR, 4'd7);
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'hC0DE_0040 + 32'(i);
            #1 wait_for(3);
            held = bus.rdata;
            @(negedge clk); #1;
            checks++;
            if ({bus.rvalid, bus.rdata, bus.rlast} !== {1'b1, held, i == 3}) begin
                failures++;
                $display("FAIL burst_stall beat=%0d got=%h exp=%h", i,
                         {bus.rvalid, bus.rdata, bus.rlast}, {1'b1, held, i == 3});
            end
            r_take(d, id, resp, last);
            checks++;
            if ({d, id, resp, last} !== {exp_d, 4'd7, 2'd0, i == 3}) begin
                failures++;
                $display("FAIL burst_beat beat=%0d got=%h exp=%h", i,
                         {d, id, resp, last}, {exp_d, 4'd7, 2'd0, i == 3});
            end
            if (i < 3) begin
                #1;
                checks++;
                if (bus.rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_gap beat=%0d got=%b exp=0", i, bus.rvalid);
                end
            end
        end
    endtask

    task automatic test_fixed_write;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        write_words(32'h300, 4'd1, 32'h0, 32'h5555_5555, 32'h0, 32'h0);
        aw_issue(32'h300, 4'd2, BURST_FIXED, 4'd9);
        w_beat(32'hAAAA_0001, 4'hF);
        w_beat(32'hAAAA_0002, 4'hF);
        #1;
        checks++;
        if (bus.bvalid !== 1'b0) begin
            failures++;
            $display("FAIL fixed_early_b got=%b exp=0", bus.bvalid);
        end
        w_beat(32'hAAAA_0003, 4'hF);
        #1;
        checks++;
        if (bus.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL fixed_bvalid got=%b exp=1", bus.bvalid);
        end
        b_take(id, resp);
        checks++;
        if (id !== 4'd9) begin
            failures++;
            $display("FAIL fixed_bid got=%0d exp=9", id);
        end
        ar_issue(32'h300, 4'd1, BURST_INCR, 4'd0);
        r_take(d, id, resp, last);
        checks++;
        if (d !== 32'hAAAA_0003) begin
            failures++;
            $display("FAIL fixed_word got=%h exp=aaaa0003", d);
        end
        r_take(d, id, resp, last);
        checks++;
        if (d !== 32'h5555_5555) begin
            failures++;
            $display("FAIL fixed_neighbour got=%h exp=55555555", d);
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        ar_issue(32'h100, 4'd3, BURST_INCR, 4'd1);
        r_take(d, id, resp, last);
        #1 wait_for(3);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.rvalid, dut.state} !== {1'b0, IDLE}) begin
            failures++;
            $display("FAIL midrst got=%h exp=%h", {bus.rvalid, dut.state}, {1'b0, IDLE});
        end
        @(negedge clk);
        ar_issue(32'h40, 4'd0, BURST_INCR, 4'd2);
        r_take(d, id, resp, last);
        checks++;
        if ({d, id, last} !== {32'hDEAD_BEEF, 4'd2, 1'b1}) begin
            failures++;
            $display("FAIL midrst_recover got=%h exp=%h", {d, id, last}, {32'hDEAD_BEEF, 4'd2, 1'b1});
        end
    endtask

    task automatic test_error;
        logic [31:0] d;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
`ifdef AXI_RAM_RESP_ERR_EN
        ar_issue(32'h0001_0000, 4'd1, BURST_INCR, 4'd2);
        for (int i = 0; i < 2; i++) begin
            r_take(d, id, resp, last);
            checks++;
            if ({d, resp} !== {32'd0, 2'b11}) begin
                failures++;
                $display("FAIL decerr_read beat=%0d got=%h exp=%h", i, {d, resp}, {32'd0, 2'b11});
            end
        end
        aw_issue(32'h0001_0040, 4'd0, BURST_INCR, 4'd3);
        w_beat(32'h1234_5678, 4'hF);
        b_take(id, resp);
        checks++;
        if ({id, resp} !== {4'd3, 2'b11}) begin
            failures++;
            $display("FAIL decerr_write got=%h exp=%h", {id, resp}, {4'd3, 2'b11});
        end
        ar_issue(32'h40, 4'd0, BURST_INCR, 4'd0);
        r_take(d, id, resp, last);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL decerr_nowrite got=%h exp=deadbeef", d);
        end
`else
        ar_issue(32'h0001_0040, 4'd0, BURST_INCR, 4'd2);
        r_take(d, id, resp, last);
        checks++;
        if ({d, resp} !== {32'hDEAD_BEEF, 2'b00}) begin
            failures++;
            $display("FAIL alias_read got=%h exp=%h", {d, resp}, {32'hDEAD_BEEF, 2'b00});
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        @(negedge clk);
        test_reset;
        test_arbitration;
        test_strobe_write;
        test_single_read;
        test_incr_burst;
        test_fixed_write;
        test_reset_mid_burst;
        test_error;
        checks++;
        if (to_flag !== 1'b0) begin
            failures++;
            $display("FAIL handshake_timeout got=%b exp=0", to_flag);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
